fifo_tx_pack: RTL

Next-generation transmit FIFO between the APB/DMA write side and the QSPI FSM. The write side stores full WIDTH-bit words. The read side is first-word-fall-through and byte-granular: the FSM consumes 1, 2, 4… bytes per pop, so address, mode and data phases can use partial words. Added over the previous TX FIFO: runtime almost-full/almost-empty thresholds, flush, sticky overflow/underflow flags, selectable byte order, and a combinational level output.

---
 rtl/qspi_pkg.sv | 15 +
 rtl/fifo_tx_pack_if.sv | 27 ++
 rtl/fifo_tx_pack_align.sv | 20 ++
 rtl/fifo_tx_pack.sv | 138 +++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: pop size encodings and byte-count helper.
package qspi_pkg;

   typedef enum logic [1:0] {
      SZ_1B = 2'd0,
      SZ_2B = 2'd1,
      SZ_4B = 2'd2,
      SZ_8B = 2'd3
   } rd_size_e;

   function automatic int unsigned sz_bytes(input int unsigned sz);
      return 32'd1 << sz;
   endfunction

endpackage

// File: rtl/fifo_tx_pack_if.sv
// Write/read bus of the byte-granular TX FIFO.
interface fifo_tx_pack_if #(
   parameter int WIDTH = 32
);
   localparam int B  = WIDTH / 8;
   localparam int LB = $clog2(B);
   localparam int BW = LB + 1;
   localparam int SW = ($clog2(LB + 1) < 1) ? 1 : $clog2(LB + 1);

   logic             wr_en_i;
   logic [WIDTH-1:0] wr_data_i;
   logic             rd_en_i;
   logic [SW-1:0]    rd_size_i;
   logic [WIDTH-1:0] rd_data_o;
   logic             rd_valid_o;
   logic [BW-1:0]    rd_bytes_avail_o;

   modport master (
      output wr_en_i, wr_data_i, rd_en_i, rd_size_i,
      input  rd_data_o, rd_valid_o, rd_bytes_avail_o
   );

   modport slave (
      input  wr_en_i, wr_data_i, rd_en_i, rd_size_i,
      output rd_data_o, rd_valid_o, rd_bytes_avail_o
   );
endinterface

// File: rtl/fifo_tx_pack_align.sv
// Head-word shifter: moves the next unread byte to the head-byte slot.
module fifo_tx_pack_align #(
   parameter int WIDTH     = 32,
   parameter int MSB_FIRST = 1,
   localparam int BW       = $clog2(WIDTH / 8) + 1
) (
   input  logic [WIDTH-1:0] i_word,
   input  logic [BW-1:0]    i_boff,
   output logic [WIDTH-1:0] o_word
);
   logic [BW+2:0] w_sh;

   assign w_sh = {i_boff, 3'b000};

   if (MSB_FIRST != 0) begin : g_msb
      assign o_word = i_word << w_sh;
   end else begin : g_lsb
      assign o_word = i_word >> w_sh;
   end
endmodule

// File: rtl/fifo_tx_pack.sv
// TX FIFO: full-word writes, FWFT byte-granular reads toward the QSPI FSM.
import qspi_pkg::*;

module fifo_tx_pack #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int MSB_FIRST = 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   fifo_tx_pack_if.slave              bus,
   input  logic                       flush_i,
   input  logic [$clog2(DEPTH+1)-1:0] af_lvl_i,
   input  logic [$clog2(DEPTH+1)-1:0] ae_lvl_i,
   input  logic                       err_clr_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       almost_full_o,
   output logic                       almost_empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       ovf_o,
   output logic                       udf_o
);
   localparam int B  = WIDTH / 8;
   localparam int LB = $clog2(B);
   localparam int BW = LB + 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [BW-1:0]    r_boff;
   logic             r_ovf;
   logic             r_udf;

   logic             w_empty;
   logic             w_full;
   logic             w_legal;
   logic             w_retire;
   logic             w_wr_ok;
   logic [BW-1:0]    w_step;
   logic [BW-1:0]    w_nboff;
   logic [BW-1:0]    w_avail;
   logic [WIDTH-1:0] w_rd_data;

   always_comb begin
      w_empty = (r_count == '0);
      w_full  = (r_count == CW'(DEPTH));
      w_avail = w_empty ? '0 : BW'(B) - r_boff;
      w_step  = '0;
      w_legal = 1'b0;
      // Oversize codes never reach the step width, so gate before casting.
      if (int'(bus.rd_size_i) <= LB) begin
         w_step  = BW'(sz_bytes(int'(bus.rd_size_i)));
         w_legal = bus.rd_en_i && !w_empty && (w_step <= w_avail);
      end
      w_nboff  = r_boff + w_step;
      w_retire = w_legal && (w_nboff == BW'(B));
      w_wr_ok  = bus.wr_en_i && (!w_full || w_retire);
   end

   always_ff @(posedge clk) begin
      if (resetn && !flush_i && w_wr_ok) begin
         r_mem[r_wptr] <= bus.wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_boff  <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_boff  <= '0;
      end else begin
         if (w_legal) begin
            r_boff <= w_retire ? '0 : w_nboff;
         end
         if (w_retire) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_wr_ok) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_wr_ok && !w_retire) begin
            r_count <= r_count + CW'(1);
         end else if (!w_wr_ok && w_retire) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // A new error event in the clear cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (err_clr_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
         end
         if (!flush_i && bus.wr_en_i && !w_wr_ok) begin
            r_ovf <= 1'b1;
         end
         if (!flush_i && bus.rd_en_i && !w_legal) begin
            r_udf <= 1'b1;
         end
      end
   end

   fifo_tx_pack_align #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_align (
      .i_word (r_mem[r_rptr]),
      .i_boff (r_boff),
      .o_word (w_rd_data)
   );

   assign bus.rd_data_o        = w_rd_data;
   assign bus.rd_valid_o       = !w_empty;
   assign bus.rd_bytes_avail_o = w_avail;

   assign full_o         = w_full;
   assign empty_o        = w_empty;
   assign almost_full_o  = (r_count >= af_lvl_i);
   assign almost_empty_o = (r_count <= ae_lvl_i);
   assign level_o        = r_count;
   assign ovf_o          = r_ovf;
   assign udf_o          = r_udf;
endmodule
